// File: rtl/bcd_acc_sequencer_if.sv
// Command and ALU-side signal bundle for bcd_acc_sequencer.
// slave = the sequencer, master = front-end plus ALU.
interface bcd_acc_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_data;
   logic        cmd_sign;
   logic [31:0] acc;
   logic        acc_sign;
   logic        ovf;
   logic        done;
   logic        err;
   logic [31:0] alu_A;
   logic [31:0] alu_B;
   logic        alu_Sa;
   logic        alu_Sb;
   logic        alu_OP;
   logic [31:0] alu_S;
   logic        alu_ov;
   logic        alu_sign;

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_sign, alu_S, alu_ov, alu_sign,
      output cmd_ready, acc, acc_sign, ovf, done, err,
             alu_A, alu_B, alu_Sa, alu_Sb, alu_OP
   );

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_sign, alu_S, alu_ov, alu_sign,
      input  cmd_ready, acc, acc_sign, ovf, done, err,
             alu_A, alu_B, alu_Sa, alu_Sb, alu_OP
   );
endinterface

// File: rtl/bcd_acc_sequencer.sv
// Command sequencer for an external 8-digit sign-magnitude BCD ALU with accumulator.
// Optional macro BCD_SAT_EN: saturate accumulator to 99999999 on ALU overflow instead of wrapping.
module bcd_acc_sequencer #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic               clk,
   input  logic               rst,
   bcd_acc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

   // Every nibble must be a decimal digit.
   function automatic logic bcd_valid(input logic [31:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [31:0] acc_r;
   logic        acc_sign_r;
   logic        ovf_r;
   logic        done_r;
   logic        err_r;
   logic        cmd_ready_r;
   logic [31:0] alu_a_r;
   logic [31:0] alu_b_r;
   logic        alu_sa_r;
   logic        alu_sb_r;
   logic        alu_op_r;

   logic        data_ok_s;
   logic [31:0] cap_acc_s;
   logic        cap_sign_s;

   // Result selection at capture time, with negative-zero normalisation.
   always_comb begin
      data_ok_s = bcd_valid(bus.cmd_data);
`ifdef BCD_SAT_EN
      if (bus.alu_ov) begin
         cap_acc_s = 32'h9999_9999;
      end else begin
         cap_acc_s = bus.alu_S;
      end
`else
      cap_acc_s = bus.alu_S;
`endif
      if (cap_acc_s == 32'h0000_0000) begin
         cap_sign_s = 1'b0;
      end else begin
         cap_sign_s = bus.alu_sign;
      end
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         acc_r       <= 32'h0000_0000;
         acc_sign_r  <= 1'b0;
         ovf_r       <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         cmd_ready_r <= 1'b1;
         alu_a_r     <= 32'h0000_0000;
         alu_b_r     <= 32'h0000_0000;
         alu_sa_r    <= 1'b0;
         alu_sb_r    <= 1'b0;
         alu_op_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               err_r  <= 1'b0;
               if (bus.cmd_valid) begin
                  cmd_ready_r <= 1'b0;
                  if ((bus.cmd_op != 2'b00) && !data_ok_s) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                     err_r   <= 1'b1;
                  end else begin
                     case (bus.cmd_op)
                        2'b00: begin
                           acc_r      <= 32'h0000_0000;
                           acc_sign_r <= 1'b0;
                           ovf_r      <= 1'b0;
                           state_r    <= DONE;
                           done_r     <= 1'b1;
                        end
                        2'b01: begin
                           acc_r      <= bus.cmd_data;
                           acc_sign_r <= bus.cmd_sign & (bus.cmd_data != 32'h0000_0000);
                           ovf_r      <= 1'b0;
                           state_r    <= DONE;
                           done_r     <= 1'b1;
                        end
                        default: begin
                           alu_a_r  <= acc_r;
                           alu_sa_r <= acc_sign_r;
                           alu_b_r  <= bus.cmd_data;
                           alu_sb_r <= bus.cmd_sign;
                           alu_op_r <= bus.cmd_op[0];
                           cnt_r    <= 4'd0;
                           state_r  <= EXEC;
                        end
                     endcase
                  end
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            EXEC: begin
               // ALU operands stay frozen here; capture once they have settled.
               if (cnt_r == LAST_CNT) begin
                  acc_r      <= cap_acc_s;
                  acc_sign_r <= cap_sign_s;
                  ovf_r      <= ovf_r | bus.alu_ov;
                  state_r    <= DONE;
                  done_r     <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            DONE: begin
               done_r      <= 1'b0;
               err_r       <= 1'b0;
               cmd_ready_r <= 1'b1;
               state_r     <= IDLE;
            end
            default: begin
               done_r      <= 1'b0;
               err_r       <= 1'b0;
               cmd_ready_r <= 1'b1;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.acc       = acc_r;
   assign bus.acc_sign  = acc_sign_r;
   assign bus.ovf       = ovf_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.alu_A     = alu_a_r;
   assign bus.alu_B     = alu_b_r;
   assign bus.alu_Sa    = alu_sa_r;
   assign bus.alu_Sb    = alu_sb_r;
   assign bus.alu_OP    = alu_op_r;

endmodule

// File: tb/tb_bcd_acc_sequencer.sv
// Bench for bcd_acc_sequencer: two DUTs (SETTLE_CYC 2 and 1) fed identical commands,
// each with a behavioural BCD ALU. Expected values follow BCD_SAT_EN when it is defined.
module tb_bcd_acc_sequencer;

   typedef struct {
      logic [31:0] s;
      logic        ov;
      logic        sign;
   } alu_res_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic        sign;
      logic [31:0] acc;
      logic        acc_sign;
      logic        ovf;
      logic        err;
   } vec_t;

   localparam int NVEC = 21;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   bcd_acc_sequencer_if ifa ();
   bcd_acc_sequencer_if ifb ();

   bcd_acc_sequencer #(.SETTLE_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   bcd_acc_sequencer #(.SETTLE_CYC(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint bcd2int(input logic [31:0] v);
      longint r;
      r = 0;
      for (int i = 7; i >= 0; i--) begin
         r = r * 10 + longint'(v[4*i +: 4]);
      end
      return r;
   endfunction

   function automatic logic [31:0] int2bcd(input longint m);
      logic [31:0] r;
      longint      t;
      t = m;
      r = 32'h0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference ALU; a zero result from a negative A reports sign 1 (negative zero).
   function automatic alu_res_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb, input logic op);
      alu_res_t res;
      longint   va;
      longint   vb;
      longint   r;
      longint   mag;
      va = bcd2int(a);
      vb = bcd2int(b);
      if (sa) va = -va;
      if (sb ^ op) vb = -vb;
      r = va + vb;
      mag = (r < 0) ? -r : r;
      res.sign = (r < 0) || ((r == 0) && sa);
      res.ov   = (mag > 64'd99999999);
      res.s    = int2bcd(mag % 100000000);
      return res;
   endfunction

   alu_res_t res_a;
   alu_res_t res_b;

   always_comb begin
      res_a        = alu_model(ifa.alu_A, ifa.alu_B, ifa.alu_Sa, ifa.alu_Sb, ifa.alu_OP);
      ifa.alu_S    = res_a.s;
      ifa.alu_ov   = res_a.ov;
      ifa.alu_sign = res_a.sign;
   end

   always_comb begin
      res_b        = alu_model(ifb.alu_A, ifb.alu_B, ifb.alu_Sa, ifb.alu_Sb, ifb.alu_OP);
      ifb.alu_S    = res_b.s;
      ifb.alu_ov   = res_b.ov;
      ifb.alu_sign = res_b.sign;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d, input logic s);
      ifa.cmd_valid = v; ifa.cmd_op = op; ifa.cmd_data = d; ifa.cmd_sign = s;
      ifb.cmd_valid = v; ifb.cmd_op = op; ifb.cmd_data = d; ifb.cmd_sign = s;
   endtask

   // Issue one command to both DUTs (called #1 after an edge, both idle) and check the outcome.
   task automatic run_vec(input int idx, input vec_t v, input logic [31:0] pa, input logic ps);
      int   lat_a, lat_b, exp_a, exp_b;
      logic seen_a, seen_b, arith;
      arith  = (v.op[1] == 1'b1) && !v.err;
      exp_a  = arith ? 3 : 1;
      exp_b  = arith ? 2 : 1;
      lat_a  = 0; lat_b = 0; seen_a = 1'b0; seen_b = 1'b0;
      drive(1'b1, v.op, v.data, v.sign);
      for (int c = 1; c <= 12 && !(seen_a && seen_b); c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            drive(1'b0, 2'b00, 32'h0, 1'b0);
            chk($sformatf("v%0d ready_busy", idx), 32'(ifa.cmd_ready), 32'd0);
            if (arith) begin
               chk($sformatf("v%0d alu_A", idx), ifa.alu_A, pa);
               chk($sformatf("v%0d alu_Sa", idx), 32'(ifa.alu_Sa), 32'(ps));
               chk($sformatf("v%0d alu_B", idx), ifa.alu_B, v.data);
               chk($sformatf("v%0d alu_Sb", idx), 32'(ifa.alu_Sb), 32'(v.sign));
               chk($sformatf("v%0d alu_OP", idx), 32'(ifa.alu_OP), 32'(v.op[0]));
            end
         end
         if (!seen_a && ifa.done) begin
            seen_a = 1'b1; lat_a = c;
            chk($sformatf("v%0d err_a", idx), 32'(ifa.err), 32'(v.err));
         end
         if (!seen_b && ifb.done) begin
            seen_b = 1'b1; lat_b = c;
            chk($sformatf("v%0d err_b", idx), 32'(ifb.err), 32'(v.err));
         end
      end
      chk($sformatf("v%0d latency_a", idx), 32'(lat_a), 32'(exp_a));
      chk($sformatf("v%0d latency_b", idx), 32'(lat_b), 32'(exp_b));
      @(posedge clk); #1;
      chk($sformatf("v%0d done_a_low", idx), 32'(ifa.done), 32'd0);
      chk($sformatf("v%0d ready_a", idx), 32'(ifa.cmd_ready), 32'd1);
      chk($sformatf("v%0d acc_a", idx), ifa.acc, v.acc);
      chk($sformatf("v%0d sign_a", idx), 32'(ifa.acc_sign), 32'(v.acc_sign));
      chk($sformatf("v%0d ovf_a", idx), 32'(ifa.ovf), 32'(v.ovf));
      chk($sformatf("v%0d acc_b", idx), ifb.acc, v.acc);
      chk($sformatf("v%0d sign_b", idx), 32'(ifb.acc_sign), 32'(v.acc_sign));
      chk($sformatf("v%0d ovf_b", idx), 32'(ifb.ovf), 32'(v.ovf));
   endtask

   vec_t vecs [NVEC];

   initial begin
      logic [31:0] pa;
      logic        ps;
      logic        seen;
      vec_t        tail;
      n_total = 0;
      n_pass  = 0;

      //          op     data          sg    acc           sg    ovf   err
      vecs[0]  = '{2'b00, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'b01, 32'h00001234, 1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{2'b10, 32'h00000766, 1'b0, 32'h00002000, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{2'b01, 32'h00000100, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'b11, 32'h00000250, 1'b0, 32'h00000150, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{2'b10, 32'h00000050, 1'b1, 32'h00000200, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{2'b11, 32'h00000300, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{2'b01, 32'h99999999, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
`ifdef BCD_SAT_EN
      vecs[8]  = '{2'b10, 32'h00000001, 1'b0, 32'h99999999, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{2'b11, 32'h00000001, 1'b0, 32'h99999998, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{2'b10, 32'h0000000A, 1'b0, 32'h99999998, 1'b0, 1'b1, 1'b1};
`else
      vecs[8]  = '{2'b10, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{2'b11, 32'h00000001, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{2'b10, 32'h0000000A, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b1};
`endif
      vecs[11] = '{2'b01, 32'h00000005, 1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{2'b10, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{2'b01, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{2'b01, 32'h99999999, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
`ifdef BCD_SAT_EN
      vecs[15] = '{2'b10, 32'h00000002, 1'b0, 32'h99999999, 1'b0, 1'b1, 1'b0};
`else
      vecs[15] = '{2'b10, 32'h00000002, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0};
`endif
      vecs[16] = '{2'b00, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{2'b01, 32'h000000F0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{2'b01, 32'h99999999, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
`ifdef BCD_SAT_EN
      vecs[19] = '{2'b10, 32'h00000001, 1'b0, 32'h99999999, 1'b0, 1'b1, 1'b0};
      vecs[20] = '{2'b10, 32'h00000123, 1'b0, 32'h99999999, 1'b0, 1'b1, 1'b0};
`else
      vecs[19] = '{2'b10, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[20] = '{2'b10, 32'h00000123, 1'b0, 32'h00000123, 1'b0, 1'b1, 1'b0};
`endif

      rst = 1'b1;
      drive(1'b0, 2'b00, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst acc", ifa.acc, 32'h0);
      chk("rst sign", 32'(ifa.acc_sign), 32'd0);
      chk("rst ovf", 32'(ifa.ovf), 32'd0);
      chk("rst done", 32'(ifa.done), 32'd0);
      chk("rst err", 32'(ifa.err), 32'd0);
      chk("rst ready", 32'(ifa.cmd_ready), 32'd1);
      chk("rst alu_A", ifa.alu_A, 32'h0);
      chk("rst alu_B", ifa.alu_B, 32'h0);
      chk("rst alu_ctl", {29'd0, ifa.alu_Sa, ifa.alu_Sb, ifa.alu_OP}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle ready", 32'(ifa.cmd_ready), 32'd1);

      pa = 32'h0;
      ps = 1'b0;
      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i], pa, ps);
         pa = vecs[i].acc;
         ps = vecs[i].acc_sign;
      end

      // Reset while dut_a is still settling an ADD.
      drive(1'b1, 2'b10, 32'h00000001, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 2'b00, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk("exec busy", {30'd0, ifa.done, ifa.cmd_ready}, 32'd0);
      rst = 1'b1;
      #2;
      chk("midrst acc", ifa.acc, 32'h0);
      chk("midrst sign", 32'(ifa.acc_sign), 32'd0);
      chk("midrst ovf", 32'(ifa.ovf), 32'd0);
      chk("midrst ready", 32'(ifa.cmd_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         seen = seen | ifa.done;
      end
      chk("midrst no_done", 32'(seen), 32'd0);
      chk("midrst acc_after", ifa.acc, 32'h0);
      chk("midrst ready_after", 32'(ifa.cmd_ready), 32'd1);

      tail = '{2'b01, 32'h00000042, 1'b0, 32'h00000042, 1'b0, 1'b0, 1'b0};
      run_vec(NVEC, tail, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
